// File: rtl/and4_bist_ctrl.sv
// ---------------------------------------------------------------------------
// and4_bist_ctrl
//
// Built-in self-test sequencer for the 4-input AND gate datapath. A start
// request in IDLE walks vec through every input combination 0 .. 2^N_IN-1.
// Each vector is held for SETTLE cycles (WAIT) and the observed gate output
// is then compared against &vec in a single CHECK cycle. The run ends in a
// one-cycle DONE state that pulses done and publishes pass.
//
// Optional feature macro: ABORT_EN
//   When defined, an extra input 'abort' cancels a run in WAIT or CHECK and
//   returns the FSM to IDLE without a done pulse. Partial err_cnt, fail_vec
//   and fail_valid are kept.
//
// Ports:
//   clk         in   1      system clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      run request, sampled only in IDLE
//   f_obs       in   1      observed gate output, sampled only in CHECK
//   abort       in   1      (ABORT_EN only) cancel the current run
//   vec         out  N_IN   stimulus, vec[N_IN-1]=a ... vec[0]=d
//   busy        out  1      high from start acceptance until DONE exits
//   done        out  1      one-cycle pulse at the end of a run
//   pass        out  1      run result, valid from done until next start
//   err_cnt     out  ERR_W  saturating mismatch count
//   fail_vec    out  N_IN   first mismatching vector
//   fail_valid  out  1      fail_vec holds a captured vector
// ---------------------------------------------------------------------------
module and4_bist_ctrl #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             f_obs,
`ifdef ABORT_EN
  input  logic             abort,
`endif
  output logic [N_IN-1:0]  vec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N_IN-1:0]  fail_vec,
  output logic             fail_valid
);

  // A settle time of zero would leave no cycle for vec to reach the gate.
  if (SETTLE < 1) begin : g_bad_settle
    $error("and4_bist_ctrl: SETTLE must be >= 1");
  end

  localparam int               CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [N_IN-1:0]  VEC_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [N_IN-1:0]  r_vec;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [N_IN-1:0]  r_fail_vec;
  logic             r_fail_valid;

  logic             w_abort;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_next;

`ifdef ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_mismatch = (f_obs != (&r_vec));
  // Count value after this CHECK; also feeds pass so a miss on the last
  // vector is reflected in the same DONE cycle.
  assign w_err_next = (w_mismatch && (r_err != ERR_MAX)) ? r_err + 1'b1 : r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_vec        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
      r_fail_vec   <= '0;
      r_fail_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_vec        <= '0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
            r_pass       <= 1'b0;
            r_cnt        <= '0;
            r_busy       <= 1'b1;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_abort) begin
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_CHECK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          // Abort wins over the compare: the partial results stay as they were.
          if (w_abort) begin
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_err <= w_err_next;
            if (w_mismatch && !r_fail_valid) begin
              r_fail_vec   <= r_vec;
              r_fail_valid <= 1'b1;
            end
            if (r_vec == VEC_LAST) begin
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
              r_state <= S_DONE;
            end else begin
              r_vec   <= r_vec + 1'b1;
              r_cnt   <= '0;
              r_state <= S_WAIT;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vec        = r_vec;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_cnt    = r_err;
  assign fail_vec   = r_fail_vec;
  assign fail_valid = r_fail_valid;

endmodule

// File: doc/and4_bist_ctrl.md
Name: and4_bist_ctrl

Overview:
Built-in self-test sequencer for the lab's 4-input AND gate datapath (and4gate). On a start pulse it drives every input combination onto the gate's a/b/c/d inputs and waits a programmable settle time. It then compares the observed output f against the expected AND of the vector and reports pass/fail, the error count and the first failing vector. It is the hardware equivalent of the exhaustive bench loop, so the gate can be checked on the board without a simulator.

Parameters:
N_IN, 4, number of gate inputs; vec width; 2^N_IN vectors per run
SETTLE, 1, cycles between applying a vector and sampling f_obs; must be >= 1 (elaboration error otherwise)
ERR_W, 5, width of error counter; saturating

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  run request; sampled only in IDLE
f_obs  in  1  observed gate output f
vec  out  N_IN  stimulus; vec[N_IN-1]=a ... vec[0]=d
busy  out  1  high from start acceptance until DONE state exits
done  out  1  one-cycle pulse at end of run
pass  out  1  run result; valid from done until next start accepted
err_cnt  out  ERR_W  mismatches in current/last run
fail_vec  out  N_IN  first mismatching vector
fail_valid  out  1  fail_vec holds a captured vector

Behaviour:
- Clock and reset: one clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, vec=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, fail_valid=0. All outputs are registered.
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE:
  - On start=1: vec<=0, err_cnt<=0, fail_valid<=0, fail_vec<=0, pass<=0, settle counter<=0, busy<=1, go to WAIT.
  - Otherwise hold all outputs.
- WAIT:
  - Increment the settle counter.
  - When the counter reaches SETTLE-1, go to CHECK. WAIT therefore lasts exactly SETTLE cycles.
- CHECK:
  - expected = &vec.
  - If f_obs != expected: err_cnt <= err_cnt+1, saturating at 2^ERR_W-1.
  - If f_obs != expected and fail_valid=0: fail_vec<=vec, fail_valid<=1.
  - If vec is all-ones, go to DONE. Otherwise vec<=vec+1, reset the settle counter, go to WAIT.
- DONE:
  - done=1 for exactly this cycle; pass<=(final err_cnt==0), including a mismatch on the last CHECK.
  - busy<=0 on exit; vec holds all-ones; go to IDLE.
- Latency: each vector takes SETTLE+1 cycles.
  - Start is sampled in cycle 0.
  - The first CHECK is in cycle SETTLE+1.
  - done is high in cycle 2^N_IN*(SETTLE+1)+1. Default: cycle 33.
- Boundaries:
  - start while busy or in DONE is ignored; it is accepted only in IDLE.
  - start held high continuously: a new run begins the cycle after DONE, back-to-back.
  - vec never wraps inside a run; the all-ones vector terminates the run.
  - err_cnt saturates and does not wrap.
  - rst_n asserted mid-run: all outputs return to reset values immediately. There is no done pulse and pass=0.
  - f_obs is sampled only in CHECK; its value in other states is don't-care.

Optional Feature:
ABORT_EN
- Defined:
  - Adds an input port abort (1 bit).
  - abort=1 in WAIT or CHECK: next state is IDLE, busy<=0, pass<=0, done stays 0, err_cnt/fail_vec/fail_valid keep their partial values.
  - abort has priority over CHECK's state update in the same cycle.
  - abort in IDLE or DONE has no effect.
- Not defined: the port is absent and a run always completes unless reset.

Test Plan:
1. Ideal DUT: f_obs=&vec, SETTLE=1, start pulse -> vec steps 0..15, done pulses in cycle 33, pass=1, err_cnt=0, fail_valid=0.
2. Stuck-at-0: f_obs=0 -> err_cnt=1, fail_vec=4'b1111, fail_valid=1, pass=0.
3. Stuck-at-1: f_obs=1 -> err_cnt=15, fail_vec=4'b0000. Rerun with ERR_W=3 -> err_cnt saturates at 7.
4. SETTLE=3, ideal DUT; second start pulse while busy -> each vec held 4 cycles, done in cycle 65, exactly one done pulse, second start ignored.
5. rst_n low during WAIT at vec=5 -> all outputs 0 asynchronously, no done. After release, start -> full clean run with pass=1.
6. ABORT_EN defined: abort=1 during CHECK at vec=9 -> IDLE next cycle, busy=0, done never pulses, pass=0, next start gives a full run.
